hilo_muldiv: RTL and testbench
==============================

Name: hilo_muldiv

Overview:
- Multi-cycle multiply/divide unit in the execute stage, beside the combinational ALU.
- Takes the ALU operands (x, y) and the ALU 4-bit select code; the MUL (sel 3) and DIV (sel 4) encodings are the same as the ALU's.
- Runs iterative shift-add multiply or restoring divide and writes the 64-bit outcome into architectural HI/LO registers.
- Drives a busy stall to the controller; writeback reads hi/lo.

Parameters:
- WIDTH, 32: operand width; HI and LO are each WIDTH bits.
- CNT_W, 6: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  request; sampled only in IDLE.
- sel  input  4  ALU select code; 4'd3 = unsigned multiply, 4'd4 = unsigned divide, other values ignored.
- x  input  WIDTH  multiplicand / dividend.
- y  input  WIDTH  multiplier / divisor.
- wr_hi  input  1  direct write of HI (move-to-HI).
- wr_lo  input  1  direct write of LO (move-to-LO).
- wr_data  input  WIDTH  data for wr_hi / wr_lo.
- busy  output  1  operation in progress; controller stalls.
- done  output  1  one-cycle pulse when HI/LO receive a result.
- div_by_zero  output  1  last divide had y==0; held until the next accepted start.
- hi  output  WIDTH  HI register; product[63:32] or remainder.
- lo  output  WIDTH  LO register; product[31:0] or quotient.

Behaviour:
- Reset (async, rst=1): state=IDLE; hi=lo=0; busy=done=div_by_zero=0; counter=0.
- States: IDLE, MUL, DIV, FIN.
- IDLE:
  - start=1 with sel==3: latch x, y; go to MUL.
  - start=1 with sel==4 and y!=0: latch x, y; go to DIV.
  - start=1 with sel==4 and y==0: go to FIN.
  - Any accepted start clears div_by_zero.
  - start with any other sel: ignored, stay IDLE.
- MUL: one shift-add step per cycle, WIDTH cycles. The 64-bit accumulator is zero-extended; no sign handling. Then go to FIN.
- DIV: one restoring step per cycle (shift remainder, trial subtract, set quotient bit), WIDTH cycles. Then go to FIN.
- FIN (one cycle):
  - hi/lo are written on the edge leaving FIN, and done=1 during the following cycle, in IDLE.
  - Divide by zero: lo=all ones, hi=x, div_by_zero=1.
- Latency: start accepted at edge 0 → done high in cycle WIDTH+2 (34 for WIDTH=32). Divide by zero: done high in cycle 2.
- busy: 1 from the cycle after start is accepted through FIN; 0 in IDLE, including the done cycle.
- start while busy: ignored, no queueing. The upstream stall guarantees operands are held, but the unit uses only the latched copies.
- wr_hi / wr_lo:
  - Honoured only in IDLE; the register updates at the next edge. Both may be asserted in the same cycle.
  - Ignored while busy.
  - If start is accepted in the same cycle, start wins and the writes are dropped.
- hi/lo hold their values between operations and do not change during iterations; the working registers are separate.
- Reset mid-operation: immediate return to IDLE with the reset values above; no done pulse.

Optional Feature:
- Macro: HILO_MULDIV_FAST_MUL_EN.
- Defined: MUL completes through a combinational WIDTHxWIDTH product. The MUL state lasts one cycle, so done is high in cycle 3 after start. DIV timing is unchanged.
- Undefined: iterative shift-add multiply, latency as in Behaviour. No multiplier is inferred.

Decomposition:
- Shared package muldiv_pkg:
  - SEL_MUL = 4'd3 and SEL_DIV = 4'd4, using the same encoding as the ALU select.
  - State enum {IDLE, MUL, DIV, FIN}.
  - Default WIDTH.
- One natural sub-module, div_step: combinational restoring-divide step.
  - Inputs: partial remainder, dividend bit, divisor.
  - Outputs: next remainder, quotient bit.

Test Plan:
- MUL x=0x0001_0000, y=0x0001_0000 → hi=0x0000_0001, lo=0x0000_0000; done in cycle 34; busy high cycles 1-33.
- MUL x=0xFFFF_FFFF, y=0xFFFF_FFFF → hi=0xFFFF_FFFE, lo=0x0000_0001.
- DIV x=100, y=7 → lo=14, hi=2, div_by_zero=0. Next: DIV x=0x0000_1234, y=0 → lo=0xFFFF_FFFF, hi=0x0000_1234, div_by_zero=1, done in cycle 2.
- Start DIV x=1000, y=3; at cycle 5 assert start with sel=3 (ignored); at cycle 10 pulse rst → busy=0, hi=lo=0, no done pulse. A later DIV 1000/3 → lo=333, hi=1.
- IDLE, wr_hi=1, wr_data=0xDEAD_BEEF, no start → hi=0xDEAD_BEEF next cycle. Then wr_lo=1 together with an accepted MUL start (x=2, y=3) → write dropped; final lo=6, hi=0.
- With HILO_MULDIV_FAST_MUL_EN: MUL x=7, y=6 → lo=42, done in cycle 3. DIV 100/7 → done still in cycle 34.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: ALU select codes
// for MUL/DIV, the control FSM state type and default sizing.
package muldiv_pkg;

    // Same encodings as the ALU select field
    localparam logic [3:0] SEL_MUL = 4'd3;
    localparam logic [3:0] SEL_DIV = 4'd4;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_t;

endpackage

// File: rtl/hilo_muldiv_div_step.sv
// One restoring-divide step: shift the dividend bit into the partial
// remainder, trial-subtract the divisor, keep the difference if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Trial subtract; a clear top bit of the difference means no borrow
    always_comb begin
        shifted = {rem_i, bit_i};
        diff    = shifted - {1'b0, div_i};
        q_o     = ~diff[WIDTH];
        rem_o   = q_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/hilo_muldiv.sv
// Multi-cycle unsigned multiply/divide unit with architectural HI/LO.
// Optional macro HILO_MULDIV_FAST_MUL_EN: single-cycle combinational
// multiply in the MUL state instead of the iterative shift-add.
module hilo_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Multiplicand (MUL) or divisor (DIV), latched at start
    logic [WIDTH-1:0]   m_q, m_d;
    // Working register: MUL {acc, multiplier}; DIV {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic               dbz_pend_q, dbz_pend_d;

    logic               accept;
    logic [WIDTH-1:0]   rem_next;
    logic               q_bit;
`ifndef HILO_MULDIV_FAST_MUL_EN
    logic [WIDTH:0]     mul_sum;
`endif

    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_i (prod_q[2*WIDTH-1:WIDTH]),
        .bit_i (prod_q[WIDTH-1]),
        .div_i (m_q),
        .rem_o (rem_next),
        .q_o   (q_bit)
    );

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            m_q        <= '0;
            prod_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
            dbz_q      <= 1'b0;
            dbz_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            m_q        <= m_d;
            prod_q     <= prod_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
            dbz_q      <= dbz_d;
            dbz_pend_q <= dbz_pend_d;
        end
    end

    // Next-state, iteration datapath and HI/LO update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        m_d        = m_q;
        prod_d     = prod_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        dbz_d      = dbz_q;
        dbz_pend_d = dbz_pend_q;
        accept     = start && (sel == SEL_MUL || sel == SEL_DIV);
`ifndef HILO_MULDIV_FAST_MUL_EN
        mul_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                   + (prod_q[0] ? {1'b0, m_q} : '0);
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d      = '0;
                    dbz_d      = 1'b0;
                    dbz_pend_d = 1'b0;
                    if (sel == SEL_MUL) begin
                        m_d     = x;
                        prod_d  = {{WIDTH{1'b0}}, y};
                        state_d = MUL;
                    end else if (y != '0) begin
                        m_d     = y;
                        prod_d  = {{WIDTH{1'b0}}, x};
                        state_d = DIV;
                    end else begin
                        // Divide by zero: preload the final HI/LO image
                        prod_d     = {x, {WIDTH{1'b1}}};
                        dbz_pend_d = 1'b1;
                        state_d    = FIN;
                    end
                end else begin
                    if (wr_hi) hi_d = wr_data;
                    if (wr_lo) lo_d = wr_data;
                end
            end
            MUL: begin
`ifdef HILO_MULDIV_FAST_MUL_EN
                prod_d  = {{WIDTH{1'b0}}, m_q} * {{WIDTH{1'b0}}, prod_q[WIDTH-1:0]};
                state_d = FIN;
`else
                prod_d = {mul_sum, prod_q[WIDTH-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = FIN;
                end
`endif
            end
            DIV: begin
                prod_d = {rem_next, prod_q[WIDTH-2:0], q_bit};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = FIN;
                end
            end
            FIN: begin
                hi_d    = prod_q[2*WIDTH-1:WIDTH];
                lo_d    = prod_q[WIDTH-1:0];
                done_d  = 1'b1;
                if (dbz_pend_q) dbz_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed cases plus random traffic,
// compared every cycle against a transaction-level model.
module tb_hilo_muldiv;

    localparam int W = 32;
`ifdef HILO_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 3;
`else
    localparam int MUL_LAT = W + 2;
`endif
    localparam int DIV_LAT = W + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    sel = 4'd0;
    logic [W-1:0]  x = '0, y = '0, wr_data = '0;
    logic          wr_hi = 1'b0, wr_lo = 1'b0;
    logic          busy, done, div_by_zero;
    logic [W-1:0]  hi, lo;

    int checks = 0;
    int errors = 0;

    hilo_muldiv #(
        .WIDTH(W),
        .CNT_W(6)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .sel(sel), .x(x), .y(y),
        .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Model: a pending result plus a count of cycles until it lands
    int           m_left;
    logic [63:0]  m_res;
    logic         m_pdbz;
    logic [W-1:0] m_hi, m_lo;
    logic         m_done, m_dbz;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0; m_res <= '0; m_pdbz <= 1'b0;
            m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_dbz <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left == 0) begin
                if (start && (sel == 4'd3 || sel == 4'd4)) begin
                    m_dbz <= 1'b0;
                    if (sel == 4'd3) begin
                        m_res <= {32'b0, x} * {32'b0, y};
                        m_pdbz <= 1'b0; m_left <= MUL_LAT - 1;
                    end else if (y == 0) begin
                        m_res <= {x, 32'hFFFF_FFFF};
                        m_pdbz <= 1'b1; m_left <= 1;
                    end else begin
                        m_res <= {x % y, x / y};
                        m_pdbz <= 1'b0; m_left <= DIV_LAT - 1;
                    end
                end else begin
                    if (wr_hi) m_hi <= wr_data;
                    if (wr_lo) m_lo <= wr_data;
                end
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi <= m_res[63:32];
                    m_lo <= m_res[31:0];
                    m_done <= 1'b1;
                    if (m_pdbz) m_dbz <= 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (!rst) begin
            check("busy", 64'(busy), 64'(m_left != 0));
            check("done", 64'(done), 64'(m_done));
            check("dbz",  64'(div_by_zero), 64'(m_dbz));
            check("hi",   64'(hi), 64'(m_hi));
            check("lo",   64'(lo), 64'(m_lo));
        end
    end

    // Called just after a negedge: request an op and count cycles to done
    task automatic run_op(input logic [3:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int n);
        start = 1'b1; sel = s; x = a; y = b;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            start = 1'b0; wr_lo = 1'b0; wr_hi = 1'b0;
        end while (!done && n < 100);
        if (!done) check("done_timeout", 64'(n), 64'(0));
    endtask

    int n;
    int done_seen;

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_done", 64'(done), 64'(0));

        run_op(4'd3, 32'h0001_0000, 32'h0001_0000, n);
        check("mul1_lat", 64'(n), 64'(MUL_LAT));
        check("mul1_hi", 64'(hi), 64'h1);
        check("mul1_lo", 64'(lo), 64'h0);

        run_op(4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
        check("mul2_hi", 64'(hi), 64'hFFFF_FFFE);
        check("mul2_lo", 64'(lo), 64'h1);

        run_op(4'd4, 32'd100, 32'd7, n);
        check("div1_lat", 64'(n), 64'(DIV_LAT));
        check("div1_lo", 64'(lo), 64'd14);
        check("div1_hi", 64'(hi), 64'd2);
        check("div1_dbz", 64'(div_by_zero), 64'(0));

        run_op(4'd4, 32'h0000_1234, 32'd0, n);
        check("dbz_lat", 64'(n), 64'(2));
        check("dbz_lo", 64'(lo), 64'hFFFF_FFFF);
        check("dbz_hi", 64'(hi), 64'h1234);
        check("dbz_flag", 64'(div_by_zero), 64'(1));

        // Ignored start while busy, then reset mid-divide
        start = 1'b1; sel = 4'd4; x = 32'd1000; y = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c == 5) begin start = 1'b1; sel = 4'd3; end
            if (c == 6) begin start = 1'b0; sel = 4'd4; end
        end
        #1 rst = 1'b1;
        #2;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_hi", 64'(hi), 64'(0));
        check("midrst_lo", 64'(lo), 64'(0));
        rst = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("midrst_nodone", 64'(done_seen), 64'(0));

        run_op(4'd4, 32'd1000, 32'd3, n);
        check("div2_lo", 64'(lo), 64'd333);
        check("div2_hi", 64'(hi), 64'd1);

        // Direct HI write, then LO write dropped in favour of an accepted start
        wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF;
        @(negedge clk);
        wr_hi = 1'b0;
        check("wrhi", 64'(hi), 64'hDEAD_BEEF);
        wr_lo = 1'b1; wr_data = 32'h5555_5555;
        run_op(4'd3, 32'd2, 32'd3, n);
        check("wrlo_drop_lo", 64'(lo), 64'd6);
        check("wrlo_drop_hi", 64'(hi), 64'd0);

        // Random traffic: starts (some while busy), odd sels, zero divisors, writes
        repeat (3000) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 4))
                0, 1:    sel = 4'd3;
                2, 3:    sel = 4'd4;
                default: sel = 4'($urandom);
            endcase
            x = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            case ($urandom_range(0, 7))
                0:       y = '0;
                1, 2:    y = 32'($urandom_range(1, 15));
                default: y = $urandom;
            endcase
            wr_hi = ($urandom_range(0, 7) == 0);
            wr_lo = ($urandom_range(0, 7) == 0);
            wr_data = $urandom;
        end
        @(negedge clk);
        start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        repeat (40) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
